// File: rtl/mem_responder.sv
// mem_responder -- single-port word memory shared by an instruction-fetch
// port (IFU) and a load/store port (LSU). One request is in service at a time.
// Each response arrives LATENCY cycles after the request is accepted.
//
// The memory is 2**DEPTH_W 32-bit words. Word 0 sits at byte address BASE.
// Reads always return the whole aligned word. A store writes only the byte
// lanes that are enabled, and it commits on the edge that ends its response
// cycle. A reset that arrives before that edge therefore drops the store.
// Out-of-range accesses still get a response with normal timing: a read
// returns zero and a store is discarded.
//
// When both ports are busy, one request waits in a single pending slot. LSU
// wins a simultaneous request. A request from the idle port, arriving while
// another request is in service, goes into the pending slot.
//
// Optional build macro MEM_RESPONDER_RANDOM_DELAY_EN adds 0..3 extra wait
// cycles per request. The extra count comes from a 16-bit LFSR.
//
// Ports:
//   clock, reset_n                 rising-edge clock, async active-low reset
//   io_ifu_reqValid / io_ifu_addr  fetch request pulse and byte address
//   io_ifu_respValid / io_ifu_rdata  fetch response pulse and word
//   io_lsu_reqValid, io_lsu_addr, io_lsu_size, io_lsu_wen,
//   io_lsu_wdata, io_lsu_wmask     load/store request
//   io_lsu_respValid / io_lsu_rdata  load/store response pulse and word
module mem_responder #(
  parameter int          DEPTH_W = 12,
  parameter int          LATENCY = 2,
  parameter logic [31:0] BASE    = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_ifu_reqValid,
  input  logic [31:0] io_ifu_addr,
  output logic        io_ifu_respValid,
  output logic [31:0] io_ifu_rdata,
  input  logic        io_lsu_reqValid,
  input  logic [31:0] io_lsu_addr,
  input  logic [1:0]  io_lsu_size,
  input  logic        io_lsu_wen,
  input  logic [31:0] io_lsu_wdata,
  input  logic [3:0]  io_lsu_wmask,
  output logic        io_lsu_respValid,
  output logic [31:0] io_lsu_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic        lsu;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  logic [31:0] mem [0:(1<<DEPTH_W)-1];

  logic [1:0]  state;
  logic [4:0]  cnt;
  req_t        cur, pend, nxt, pnew, ifu_req, lsu_req, other;
  logic        pend_valid;
  logic        launch, to_pend, pend_clr, viol;
  logic        own_req, other_req;
  logic [4:0]  wait_len;

  always_comb begin
    ifu_req       = '0;
    ifu_req.addr  = io_ifu_addr;
    ifu_req.size  = 2'd2;
    lsu_req.lsu   = 1'b1;
    lsu_req.addr  = io_lsu_addr;
    lsu_req.size  = io_lsu_size;
    lsu_req.wen   = io_lsu_wen;
    lsu_req.wdata = io_lsu_wdata;
    lsu_req.wmask = io_lsu_wmask;
  end

  // Requests are classified relative to the port that currently owns the
  // memory. The pending slot can only ever hold the other port.
  assign own_req   = cur.lsu ? io_lsu_reqValid : io_ifu_reqValid;
  assign other_req = cur.lsu ? io_ifu_reqValid : io_lsu_reqValid;
  assign other     = cur.lsu ? ifu_req : lsu_req;

  always_comb begin
    launch   = 1'b0;
    to_pend  = 1'b0;
    pend_clr = 1'b0;
    viol     = 1'b0;
    nxt      = cur;
    pnew     = pend;
    case (state)
      IDLE: begin
        if (io_lsu_reqValid) begin
          launch = 1'b1;
          nxt    = lsu_req;
          if (io_ifu_reqValid) begin
            to_pend = 1'b1;
            pnew    = ifu_req;
          end
        end else if (io_ifu_reqValid) begin
          launch = 1'b1;
          nxt    = ifu_req;
        end
      end
      WAIT: begin
        if (other_req && !pend_valid) begin
          to_pend = 1'b1;
          pnew    = other;
        end
        viol = own_req || (other_req && pend_valid);
      end
      RESP: begin
        // Chain straight into the next request so there is no idle bubble.
        if (pend_valid) begin
          launch   = 1'b1;
          nxt      = pend;
          pend_clr = 1'b1;
          viol     = own_req || other_req;
        end else if (other_req) begin
          launch = 1'b1;
          nxt    = other;
          viol   = own_req;
        end else begin
          viol = own_req;
        end
      end
      default: ;
    endcase
  end

`ifdef MEM_RESPONDER_RANDOM_DELAY_EN
  logic [15:0] lfsr;
  assign wait_len = 5'(LATENCY - 1) + {3'd0, lfsr[1:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      lfsr <= 16'hACE1;
    else if (launch)
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`else
  assign wait_len = 5'(LATENCY - 1);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cur        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (launch) begin
        cur <= nxt;
        // A total wait of zero goes straight to RESP. Otherwise cnt holds
        // the number of WAIT cycles left after the current one.
        if (wait_len == 5'd0) begin
          state <= RESP;
        end else begin
          state <= WAIT;
          cnt   <= wait_len - 5'd1;
        end
      end else begin
        case (state)
          WAIT: begin
            if (cnt == 5'd0) state <= RESP;
            else             cnt   <= cnt - 5'd1;
          end
          RESP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
      if (pend_clr) pend_valid <= 1'b0;
      if (to_pend) begin
        pend_valid <= 1'b1;
        pend       <= pnew;
      end
    end
  end

  // Address decode for the request in service.
  logic [31:0]        offset;
  logic               in_range;
  logic [DEPTH_W-1:0] idx;
  logic [31:0]        rd_word;

  assign offset   = cur.addr - BASE;
  assign in_range = (cur.addr >= BASE) && ((offset >> (DEPTH_W + 2)) == 32'd0);
  assign idx      = offset[DEPTH_W+1:2];

  // The memory has no reset. A store commits on the edge that ends RESP.
  always_ff @(posedge clock) begin
    if (state == RESP && cur.wen && in_range)
      for (int b = 0; b < 4; b++)
        if (cur.wmask[b]) mem[idx][8*b +: 8] <= cur.wdata[8*b +: 8];
  end

  always_comb begin
    rd_word = 32'd0;
    if (in_range && !cur.wen) rd_word = mem[idx];
  end

  assign io_ifu_respValid = (state == RESP) && !cur.lsu;
  assign io_lsu_respValid = (state == RESP) &&  cur.lsu;
  assign io_ifu_rdata     = io_ifu_respValid ? rd_word : 32'd0;
  assign io_lsu_rdata     = io_lsu_respValid ? rd_word : 32'd0;

  // The access size is captured with the request but has no effect on data.
  logic unused;
  assign unused = ^cur.size;

`ifndef SYNTHESIS
  always @(posedge clock)
    if (reset_n && viol)
      $error("mem_responder: request from a busy or already-pending port ignored");
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  localparam int          DEPTH_W = 12;
  localparam int          LATENCY = 2;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          DEPTH   = 1 << DEPTH_W;
`ifdef MEM_RESPONDER_RANDOM_DELAY_EN
  localparam int XMAX = 3;
  localparam int NB2B = 100;
`else
  localparam int XMAX = 0;
  localparam int NB2B = 20;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ifu_req = 1'b0, lsu_req = 1'b0, lsu_wen = 1'b0;
  logic [31:0] ifu_addr = '0, lsu_addr = '0, lsu_wdata = '0;
  logic [1:0]  lsu_size = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        ifu_rv, lsu_rv;
  logic [31:0] ifu_rdata, lsu_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mdl [int];

  always #5 clock = ~clock;

  mem_responder #(.DEPTH_W(DEPTH_W), .LATENCY(LATENCY), .BASE(BASE)) dut (
    .clock(clock), .reset_n(reset_n),
    .io_ifu_reqValid(ifu_req), .io_ifu_addr(ifu_addr),
    .io_ifu_respValid(ifu_rv), .io_ifu_rdata(ifu_rdata),
    .io_lsu_reqValid(lsu_req), .io_lsu_addr(lsu_addr), .io_lsu_size(lsu_size),
    .io_lsu_wen(lsu_wen), .io_lsu_wdata(lsu_wdata), .io_lsu_wmask(lsu_wmask),
    .io_lsu_respValid(lsu_rv), .io_lsu_rdata(lsu_rdata)
  );

  // Reference model: a sparse word array indexed by word number.
  function automatic bit in_rng(input logic [31:0] a);
    longint ua = a;
    longint ub = BASE;
    return (ua - ub) >= 0 && (ua - ub) < longint'(DEPTH) * 4;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (!in_rng(a)) return 32'h0;
    return mdl[widx(a)];
  endfunction

  function automatic void mwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    if (!in_rng(a)) return;
    w = mdl.exists(widx(a)) ? mdl[widx(a)] : 32'hx;
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    mdl[widx(a)] = w;
  endfunction

  // Issues one request and waits, with a bounded number of cycles, for its
  // response. glitch is set if any unexpected output activity is seen.
  task automatic xact(input bit lsu, input logic [31:0] addr, input bit wen,
                      input logic [31:0] wdata, input logic [3:0] wmask,
                      output logic [31:0] rdata, output int lat, output bit got,
                      output bit glitch);
    got = 0; lat = 0; rdata = '0; glitch = 0;
    @(negedge clock);
    if (lsu) begin
      lsu_req = 1; lsu_addr = addr; lsu_size = 2'($urandom_range(0, 2));
      lsu_wen = wen; lsu_wdata = wdata; lsu_wmask = wmask;
    end else begin
      ifu_req = 1; ifu_addr = addr;
    end
    @(negedge clock);
    ifu_req = 0; lsu_req = 0;
    lsu_addr = $urandom; ifu_addr = $urandom; lsu_wdata = $urandom;
    lsu_wmask = 4'($urandom); lsu_wen = 1'($urandom);
    for (int k = 1; k <= 40 && !got; k++) begin
      if (k > 1) @(negedge clock);
      if (lsu ? lsu_rv : ifu_rv) begin
        got = 1; lat = k; rdata = lsu ? lsu_rdata : ifu_rdata;
        if (lsu ? ifu_rv : lsu_rv) glitch = 1;
      end else if (ifu_rv || lsu_rv || ifu_rdata !== 0 || lsu_rdata !== 0) begin
        glitch = 1;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    n_cmp += 4;
    if (ifu_rv !== 1'b0)     begin n_err++; $display("FAIL reset_ifu_rv got=%b exp=0", ifu_rv); end
    if (lsu_rv !== 1'b0)     begin n_err++; $display("FAIL reset_lsu_rv got=%b exp=0", lsu_rv); end
    if (ifu_rdata !== 32'h0) begin n_err++; $display("FAIL reset_ifu_rdata got=%h exp=0", ifu_rdata); end
    if (lsu_rdata !== 32'h0) begin n_err++; $display("FAIL reset_lsu_rdata got=%h exp=0", lsu_rdata); end
    reset_n = 1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (ifu_rv !== 1'b0 || lsu_rv !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle ifu_rv=%b lsu_rv=%b exp=0/0", ifu_rv, lsu_rv);
    end
  endtask

  task automatic test_fetch;
    logic [31:0] rd; int lat; bit got, gl;
    xact(1, BASE, 1, 32'hDEAD_BEEF, 4'hF, rd, lat, got, gl);
    mwrite(BASE, 32'hDEAD_BEEF, 4'hF);
    n_cmp += 2;
    if (!(got && lat >= LATENCY && lat <= LATENCY + XMAX))
      begin n_err++; $display("FAIL store_latency got=%0d (seen=%0b) exp=%0d..%0d", lat, got, LATENCY, LATENCY + XMAX); end
    if (rd !== 32'h0) begin n_err++; $display("FAIL store_rdata got=%h exp=0", rd); end
    xact(0, BASE, 0, 0, 0, rd, lat, got, gl);
    n_cmp += 3;
    if (!(got && lat >= LATENCY && lat <= LATENCY + XMAX))
      begin n_err++; $display("FAIL fetch_latency got=%0d (seen=%0b) exp=%0d..%0d", lat, got, LATENCY, LATENCY + XMAX); end
    if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL fetch_rdata got=%h exp=deadbeef", rd); end
    if (gl) begin n_err++; $display("FAIL fetch_glitch got=1 exp=0"); end
    @(negedge clock);
    n_cmp++;
    if (ifu_rv !== 1'b0 || ifu_rdata !== 32'h0)
      begin n_err++; $display("FAIL fetch_one_cycle rv=%b rdata=%h exp=0/0", ifu_rv, ifu_rdata); end
  endtask

  task automatic test_lanes;
    logic [31:0] rd; int lat; bit got, gl;
    xact(1, BASE + 4, 1, 32'h1111_1111, 4'hF, rd, lat, got, gl);
    mwrite(BASE + 4, 32'h1111_1111, 4'hF);
    xact(1, BASE + 4, 1, 32'h0000_AB00, 4'b0010, rd, lat, got, gl);
    mwrite(BASE + 4, 32'h0000_AB00, 4'b0010);
    xact(1, BASE + 4, 0, 0, 0, rd, lat, got, gl);
    n_cmp += 2;
    if (rd !== 32'h1111_AB11) begin n_err++; $display("FAIL lane_merge got=%h exp=1111ab11", rd); end
    if (!got || gl) begin n_err++; $display("FAIL lane_load_resp seen=%0b glitch=%0b exp=1/0", got, gl); end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, d, exp; logic [3:0] m; int lat; bit got, gl, lsu, wen;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      xact(1, BASE + 4 * i, 1, d, 4'hF, rd, lat, got, gl);
      mwrite(BASE + 4 * i, d, 4'hF);
    end
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 9) == 0) a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 15);
      else a = BASE + 4 * $urandom_range(0, 7);
      a[1:0] = 2'($urandom);
      lsu = 1'($urandom);
      wen = lsu && ($urandom_range(0, 2) == 0);
      d = $urandom; m = 4'($urandom);
      exp = wen ? 32'h0 : mread(a);
      xact(lsu, a, wen, d, m, rd, lat, got, gl);
      if (wen) mwrite(a, d, m);
      n_cmp++;
      if (!(got && !gl && rd === exp && lat >= LATENCY && lat <= LATENCY + XMAX))
        begin n_err++; $display("FAIL rand_op%0d lsu=%0b wen=%0b addr=%h got=%h lat=%0d glitch=%0b exp=%h", n, lsu, wen, a, rd, lat, gl, exp); end
    end
  endtask

  // LSU load at edge T, IFU fetch issued dly cycles later (0 = same edge).
  task automatic test_two_port(input int dly);
    logic [31:0] a, b, lrd, ird; int lk, ik; bit both;
    a = BASE + 4 * $urandom_range(0, 7);
    b = BASE + 4 * $urandom_range(0, 7);
    lk = 0; ik = 0; both = 0; lrd = 'x; ird = 'x;
    @(negedge clock);
    lsu_req = 1; lsu_addr = a; lsu_wen = 0; lsu_size = 2'd2;
    if (dly == 0) begin ifu_req = 1; ifu_addr = b; end
    @(negedge clock);
    lsu_req = 0;
    if (dly == 0) ifu_req = 0;
    for (int k = 1; k <= 60 && (lk == 0 || ik == 0); k++) begin
      if (k > 1) @(negedge clock);
      if (ifu_rv && lsu_rv) both = 1;
      if (lsu_rv && lk == 0) begin lk = k; lrd = lsu_rdata; end
      if (ifu_rv && ik == 0) begin ik = k; ird = ifu_rdata; end
      if (dly > 0 && k == dly) begin ifu_req = 1; ifu_addr = b; end
      if (dly > 0 && k == dly + 1) ifu_req = 0;
    end
    ifu_req = 0;
    n_cmp += 5;
    if (!(lk >= LATENCY && lk <= LATENCY + XMAX))
      begin n_err++; $display("FAIL dual%0d_lsu_lat got=%0d exp=%0d..%0d", dly, lk, LATENCY, LATENCY + XMAX); end
    if (!(lk > 0 && ik >= lk + LATENCY && ik <= lk + LATENCY + XMAX))
      begin n_err++; $display("FAIL dual%0d_ifu_lat got=%0d exp=%0d..%0d", dly, ik, lk + LATENCY, lk + LATENCY + XMAX); end
    if (lrd !== mread(a)) begin n_err++; $display("FAIL dual%0d_lsu_data got=%h exp=%h", dly, lrd, mread(a)); end
    if (ird !== mread(b)) begin n_err++; $display("FAIL dual%0d_ifu_data got=%h exp=%h", dly, ird, mread(b)); end
    if (both) begin n_err++; $display("FAIL dual%0d_overlap got=1 exp=0", dly); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd, top, d; int lat; bit got, gl;
    top = BASE + 4 * (DEPTH - 1);
    d = $urandom;
    xact(1, top, 1, d, 4'hF, rd, lat, got, gl);
    mwrite(top, d, 4'hF);
    xact(1, 32'h7FFF_FFFC, 0, 0, 0, rd, lat, got, gl);
    n_cmp += 2;
    if (rd !== 32'h0) begin n_err++; $display("FAIL oor_load_data got=%h exp=0", rd); end
    if (!(got && lat >= LATENCY && lat <= LATENCY + XMAX))
      begin n_err++; $display("FAIL oor_load_lat got=%0d (seen=%0b) exp=%0d..%0d", lat, got, LATENCY, LATENCY + XMAX); end
    xact(1, 32'h7FFF_FFFC, 1, ~d, 4'hF, rd, lat, got, gl);
    n_cmp++;
    if (!got || rd !== 32'h0) begin n_err++; $display("FAIL oor_store_resp seen=%0b rdata=%h exp=1/0", got, rd); end
    xact(1, BASE + 4 * DEPTH, 1, 32'h0BAD_0BAD, 4'hF, rd, lat, got, gl);
    xact(1, top, 0, 0, 0, rd, lat, got, gl);
    n_cmp++;
    if (rd !== mread(top)) begin n_err++; $display("FAIL oor_below_alias got=%h exp=%h", rd, mread(top)); end
    xact(0, BASE, 0, 0, 0, rd, lat, got, gl);
    n_cmp++;
    if (rd !== mread(BASE)) begin n_err++; $display("FAIL oor_above_alias got=%h exp=%h", rd, mread(BASE)); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, a; int lat; bit got, gl, seen;
    a = BASE + 4 * 5;
    xact(1, a, 1, 32'h5A5A_1234, 4'hF, rd, lat, got, gl);
    mwrite(a, 32'h5A5A_1234, 4'hF);
    // Store accepted, then reset while it is waiting.
    @(negedge clock);
    lsu_req = 1; lsu_addr = a; lsu_wen = 1; lsu_wdata = 32'hFFFF_FFFF; lsu_wmask = 4'hF;
    @(negedge clock);
    lsu_req = 0;
    reset_n = 0;
    #1;
    n_cmp++;
    if (lsu_rv !== 1'b0 || lsu_rdata !== 32'h0 || ifu_rv !== 1'b0)
      begin n_err++; $display("FAIL rst_wait_outputs lsu_rv=%b rdata=%h ifu_rv=%b exp=0", lsu_rv, lsu_rdata, ifu_rv); end
    repeat (2) @(negedge clock);
    reset_n = 1;
    seen = 0;
    repeat (10) begin @(negedge clock); if (lsu_rv || ifu_rv) seen = 1; end
    n_cmp++;
    if (seen) begin n_err++; $display("FAIL rst_wait_late_resp got=1 exp=0"); end
    xact(1, a, 0, 0, 0, rd, lat, got, gl);
    n_cmp++;
    if (rd !== mread(a)) begin n_err++; $display("FAIL rst_wait_store_dropped got=%h exp=%h", rd, mread(a)); end
    // Reset while a response is on the bus drops it at once.
    @(negedge clock);
    ifu_req = 1; ifu_addr = a;
    @(negedge clock);
    ifu_req = 0;
    seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (k > 1) @(negedge clock);
      if (ifu_rv) seen = 1;
    end
    reset_n = 0;
    #1;
    n_cmp++;
    if (!seen || ifu_rv !== 1'b0 || ifu_rdata !== 32'h0)
      begin n_err++; $display("FAIL rst_resp_drop seen=%0b rv=%b rdata=%h exp=1/0/0", seen, ifu_rv, ifu_rdata); end
    repeat (2) @(negedge clock);
    reset_n = 1;
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd, a; int lat; bit got, gl;
    for (int n = 0; n < NB2B; n++) begin
      a = BASE + 4 * $urandom_range(0, 7);
      xact(0, a, 0, 0, 0, rd, lat, got, gl);
      n_cmp += 2;
      if (!(got && !gl && lat >= LATENCY && lat <= LATENCY + XMAX && rd === mread(a)))
        begin n_err++; $display("FAIL b2b%0d seen=%0b glitch=%0b lat=%0d rdata=%h exp_lat=%0d..%0d exp=%h", n, got, gl, lat, rd, LATENCY, LATENCY + XMAX, mread(a)); end
      @(negedge clock);
      if (ifu_rv !== 1'b0) begin n_err++; $display("FAIL b2b%0d_single_pulse got=%b exp=0", n, ifu_rv); end
    end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_lanes;
    test_random;
    test_two_port(0);
    test_two_port(1);
    test_out_of_range;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
